// File: rtl/data_demux.sv
// -----------------------------------------------------------------------------
// data_demux
//
// Receive-side demultiplexer for the time-division stream built by data_mux.
// A dwell counter and a slot counter track where the stream is. Each slot's
// sample goes to its own output register, with a one-cycle valid strobe.
//
// Ports
//   clk               in   1   system clock, rising edge
//   rst               in   1   synchronous active-high reset
//   switch_clk_cycles in   3   dwell length N per slot (0 treated as 1)
//   mode              in   2   stream count M (0 = idle, 1..3 streams)
//   mux_valid         in   1   stream aligned; rising edge marks slot 0
//   mux_data          in   8   multiplexed data word
//   DS1_out/DS2_out/DS3_out
//                     out  8   last captured sample per stream
//   ds_valid          out  3   one-cycle capture strobe, bit k = stream k+1
//   slot              out  2   current slot index (0 in IDLE)
//   frame_cnt         out  16  completed-frame count (DEMUX_FRAME_CNT_EN only)
//
// Optional feature macro: DEMUX_FRAME_CNT_EN adds the frame_cnt output.
// -----------------------------------------------------------------------------
module data_demux (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  switch_clk_cycles,
    input  logic [1:0]  mode,
    input  logic        mux_valid,
    input  logic [7:0]  mux_data,
    output logic [7:0]  DS1_out,
    output logic [7:0]  DS2_out,
    output logic [7:0]  DS3_out,
    output logic [2:0]  ds_valid,
    output logic [1:0]  slot
`ifdef DEMUX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  n_q, n_d;
    logic [1:0]  m_q, m_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  slot_q, slot_d;
    logic [7:0]  ds1_q, ds1_d;
    logic [7:0]  ds2_q, ds2_d;
    logic [7:0]  ds3_q, ds3_d;
    logic [2:0]  ds_valid_q, ds_valid_d;
`ifdef DEMUX_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;
`endif

    // Context of the cycle being processed. In IDLE, the cycle that starts a
    // run is dwell 1 of slot 0, using the configuration being latched right now.
    logic [2:0]  eff_n_s;
    logic        active_s;
    logic [2:0]  cur_n_s;
    logic [1:0]  cur_m_s;
    logic [2:0]  cur_cnt_s;
    logic [1:0]  cur_slot_s;

    // Next-state logic for the slot/dwell tracker and the capture registers.
    always_comb begin
        eff_n_s    = (switch_clk_cycles == 3'd0) ? 3'd1 : switch_clk_cycles;

        state_d    = state_q;
        n_d        = n_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        ds1_d      = ds1_q;
        ds2_d      = ds2_q;
        ds3_d      = ds3_q;
        ds_valid_d = 3'b000;
`ifdef DEMUX_FRAME_CNT_EN
        fc_d       = fc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                active_s   = mux_valid && (mode != 2'd0);
                cur_n_s    = eff_n_s;
                cur_m_s    = mode;
                cur_cnt_s  = 3'd1;
                cur_slot_s = 2'd0;
                if (mux_valid) begin
                    n_d = eff_n_s;
                    m_d = mode;
                end else begin
                    n_d = n_q;
                    m_d = m_q;
                end
            end
            ST_RUN: begin
                active_s   = mux_valid;
                cur_n_s    = n_q;
                cur_m_s    = m_q;
                cur_cnt_s  = cnt_q;
                cur_slot_s = slot_q;
            end
            default: begin
                active_s   = 1'b0;
                cur_n_s    = 3'd1;
                cur_m_s    = 2'd0;
                cur_cnt_s  = 3'd1;
                cur_slot_s = 2'd0;
            end
        endcase

        // A dropped mux_valid aborts the run before any capture is considered.
        if (active_s) begin
            state_d = ST_RUN;
            if (cur_cnt_s == cur_n_s) begin
                case (cur_slot_s)
                    2'd0:    ds1_d = mux_data;
                    2'd1:    ds2_d = mux_data;
                    default: ds3_d = mux_data;
                endcase
                ds_valid_d = 3'b001 << cur_slot_s;
                cnt_d      = 3'd1;
                // Frame boundary: take on the new configuration for the next frame.
                if (cur_slot_s == (cur_m_s - 2'd1)) begin
                    slot_d = 2'd0;
                    n_d    = eff_n_s;
                    m_d    = mode;
`ifdef DEMUX_FRAME_CNT_EN
                    fc_d   = fc_q + 16'd1;
`endif
                    if (mode == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    slot_d = cur_slot_s + 2'd1;
                end
            end else begin
                cnt_d  = cur_cnt_s + 3'd1;
                slot_d = cur_slot_s;
            end
        end else begin
            state_d = ST_IDLE;
            cnt_d   = 3'd1;
            slot_d  = 2'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= 3'd1;
            m_q        <= 2'd0;
            cnt_q      <= 3'd1;
            slot_q     <= 2'd0;
            ds1_q      <= 8'h00;
            ds2_q      <= 8'h00;
            ds3_q      <= 8'h00;
            ds_valid_q <= 3'b000;
`ifdef DEMUX_FRAME_CNT_EN
            fc_q       <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            ds1_q      <= ds1_d;
            ds2_q      <= ds2_d;
            ds3_q      <= ds3_d;
            ds_valid_q <= ds_valid_d;
`ifdef DEMUX_FRAME_CNT_EN
            fc_q       <= fc_d;
`endif
        end
    end

    assign DS1_out  = ds1_q;
    assign DS2_out  = ds2_q;
    assign DS3_out  = ds3_q;
    assign ds_valid = ds_valid_q;
    assign slot     = slot_q;
`ifdef DEMUX_FRAME_CNT_EN
    assign frame_cnt = fc_q;
`endif

endmodule

// File: tb/tb_data_demux.sv
// -----------------------------------------------------------------------------
// tb_data_demux
//
// Directed self-checking bench for data_demux. Inputs change 1 ns after each
// rising edge, and outputs are checked at that same point, so every check
// sees the values registered on the edge just passed.
// -----------------------------------------------------------------------------
module tb_data_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  switch_clk_cycles;
    logic [1:0]  mode;
    logic        mux_valid;
    logic [7:0]  mux_data;
    logic [7:0]  DS1_out;
    logic [7:0]  DS2_out;
    logic [7:0]  DS3_out;
    logic [2:0]  ds_valid;
    logic [1:0]  slot;
`ifdef DEMUX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int total = 0;
    int bad   = 0;

    data_demux dut (
        .clk               (clk),
        .rst               (rst),
        .switch_clk_cycles (switch_clk_cycles),
        .mode              (mode),
        .mux_valid         (mux_valid),
        .mux_data          (mux_data),
        .DS1_out           (DS1_out),
        .DS2_out           (DS2_out),
        .DS3_out           (DS3_out),
        .ds_valid          (ds_valid),
        .slot              (slot)
`ifdef DEMUX_FRAME_CNT_EN
        ,
        .frame_cnt         (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [2:0] ev, input logic [1:0] es);
        check({tag, ".ds1"},   16'(DS1_out),  16'(e1));
        check({tag, ".ds2"},   16'(DS2_out),  16'(e2));
        check({tag, ".ds3"},   16'(DS3_out),  16'(e3));
        check({tag, ".valid"}, 16'(ds_valid), 16'(ev));
        check({tag, ".slot"},  16'(slot),     16'(es));
    endtask

    task automatic check_fc(input string tag, input logic [15:0] e);
`ifdef DEMUX_FRAME_CNT_EN
        check({tag, ".frame_cnt"}, frame_cnt, e);
`else
        e = e;
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mux_valid = 1'b0;
        mux_data  = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        switch_clk_cycles = 3'd0;
        mode              = 2'd0;
        mux_valid         = 1'b0;
        mux_data          = 8'h00;
        #1;
        do_reset();
        check_all("reset", 8'h00, 8'h00, 8'h00, 3'b000, 2'd0);
        check_fc("reset", 16'd0);

        // Mode 3, N=2: data 3,3,50,50,98,98 starting at cycle 1.
        mode = 2'd3; switch_clk_cycles = 3'd2; mux_valid = 1'b1;
        mux_data = 8'd3;  tick();
        check_all("t1.c2", 8'd0, 8'd0, 8'd0, 3'b000, 2'd0);
        mux_data = 8'd3;  tick();
        check_all("t1.c3", 8'd3, 8'd0, 8'd0, 3'b001, 2'd1);
        mux_data = 8'd50; tick();
        check_all("t1.c4", 8'd3, 8'd0, 8'd0, 3'b000, 2'd1);
        mux_data = 8'd50; tick();
        check_all("t1.c5", 8'd3, 8'd50, 8'd0, 3'b010, 2'd2);
        mux_data = 8'd98; tick();
        mux_data = 8'd98; tick();
        check_all("t1.c7", 8'd3, 8'd50, 8'd98, 3'b100, 2'd0);
        check_fc("t1.c7", 16'd1);
        mux_valid = 1'b0; tick();
        check_all("t1.idle", 8'd3, 8'd50, 8'd98, 3'b000, 2'd0);
        check_fc("t1.idle", 16'd1);

        // Mode 1, N=0 (as 1): every cycle captures into DS1.
        do_reset();
        mode = 2'd1; switch_clk_cycles = 3'd0; mux_valid = 1'b1;
        mux_data = 8'd6;  tick();
        check_all("t2.a", 8'd6, 8'd0, 8'd0, 3'b001, 2'd0);
        mux_data = 8'd9;  tick();
        check_all("t2.b", 8'd9, 8'd0, 8'd0, 3'b001, 2'd0);
        mux_data = 8'd12; tick();
        check_all("t2.c", 8'd12, 8'd0, 8'd0, 3'b001, 2'd0);
        check_fc("t2.c", 16'd3);
        mux_valid = 1'b0; tick();
        check_all("t2.idle", 8'd12, 8'd0, 8'd0, 3'b000, 2'd0);

        // Mode 3, N=3, config changed mid slot 1; takes effect at the frame end.
        do_reset();
        mode = 2'd3; switch_clk_cycles = 3'd3; mux_valid = 1'b1;
        mux_data = 8'd11; tick(); tick(); tick();
        check_all("t3.c4", 8'd11, 8'd0, 8'd0, 3'b001, 2'd1);
        mux_data = 8'd22; tick();
        mode = 2'd2; switch_clk_cycles = 3'd1;
        tick(); tick();
        check_all("t3.c7", 8'd11, 8'd22, 8'd0, 3'b010, 2'd2);
        mux_data = 8'd33; tick();
        check_all("t3.c8", 8'd11, 8'd22, 8'd0, 3'b000, 2'd2);
        tick(); tick();
        check_all("t3.c10", 8'd11, 8'd22, 8'd33, 3'b100, 2'd0);
        check_fc("t3.c10", 16'd1);
        mux_data = 8'd44; tick();
        check_all("t3.c11", 8'd44, 8'd22, 8'd33, 3'b001, 2'd1);
        mux_data = 8'd55; tick();
        check_all("t3.c12", 8'd44, 8'd55, 8'd33, 3'b010, 2'd0);
        check_fc("t3.c12", 16'd2);
        mux_data = 8'd66; tick();
        check_all("t3.c13", 8'd66, 8'd55, 8'd33, 3'b001, 2'd1);
        mux_valid = 1'b0; tick();

        // Mode 2, N=4, valid dropped on dwell 4 of slot 1 in the second frame.
        do_reset();
        mode = 2'd2; switch_clk_cycles = 3'd4; mux_valid = 1'b1;
        mux_data = 8'h10;
        for (int i = 0; i < 4; i++) tick();
        mux_data = 8'h20;
        for (int i = 0; i < 4; i++) tick();
        check_all("t4.f1", 8'h10, 8'h20, 8'h00, 3'b010, 2'd0);
        mux_data = 8'h30;
        for (int i = 0; i < 4; i++) tick();
        check_all("t4.s0", 8'h30, 8'h20, 8'h00, 3'b001, 2'd1);
        mux_data = 8'h40;
        for (int i = 0; i < 3; i++) tick();
        mux_valid = 1'b0; tick();
        check_all("t4.abort", 8'h30, 8'h20, 8'h00, 3'b000, 2'd0);
        check_fc("t4.abort", 16'd1);
        tick();
        check_all("t4.hold", 8'h30, 8'h20, 8'h00, 3'b000, 2'd0);

        // Mode 3, N=2, reset mid slot 2 with valid held high.
        do_reset();
        mode = 2'd3; switch_clk_cycles = 3'd2; mux_valid = 1'b1;
        mux_data = 8'd1; tick(); tick();
        mux_data = 8'd2; tick(); tick();
        check_all("t5.pre", 8'd1, 8'd2, 8'd0, 3'b010, 2'd2);
        mux_data = 8'd3; rst = 1'b1; tick();
        rst = 1'b0;
        check_all("t5.rst", 8'd0, 8'd0, 8'd0, 3'b000, 2'd0);
        check_fc("t5.rst", 16'd0);
        mux_data = 8'd7; tick();
        check_all("t5.c7", 8'd0, 8'd0, 8'd0, 3'b000, 2'd0);
        tick();
        check_all("t5.c8", 8'd7, 8'd0, 8'd0, 3'b001, 2'd1);
        mux_valid = 1'b0; tick();

        // Mode 0 with valid high: data ignored.
        do_reset();
        mode = 2'd0; switch_clk_cycles = 3'd1; mux_valid = 1'b1; mux_data = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            check(" t6.valid", 16'(ds_valid), 16'd0);
            check(" t6.slot",  16'(slot),     16'd0);
        end
        check_all("t6.end", 8'h00, 8'h00, 8'h00, 3'b000, 2'd0);
        check_fc("t6.end", 16'd0);
        mux_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_demux.md
# data_demux

Receive-side demultiplexer for the time-division stream produced by `data_mux`. It consumes the 8-bit `mux_data` word stream, tracks slot position with a dwell counter and slot counter, and routes each slot's sample to the matching output stream register (DS1/DS2/DS3) with a one-cycle valid strobe. It sits directly downstream of `data_mux` and shares its `mode` and `switch_clk_cycles` configuration.

## Interface
- No parameters; data width is fixed at 8, stream count at 3.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `switch_clk_cycles`  in  3  dwell length N in clocks per slot; 0 is treated as 1.
- `mode`  in  2  stream count M: 0 = idle, 1 = DS1 only, 2 = DS1/DS2, 3 = DS1/DS2/DS3.
- `mux_valid`  in  1  high while `mux_data` carries an aligned stream; the rising edge marks slot 0, dwell cycle 1.
- `mux_data`  in  8  multiplexed data word.
- `DS1_out`, `DS2_out`, `DS3_out`  out  8 each  last captured sample per stream.
- `ds_valid`  out  3  one-cycle strobe per stream; bit k is for stream k+1.
- `slot`  out  2  current slot index (0..M-1) while RUN; 0 in IDLE.
- `frame_cnt`  out  16  completed-frame count; present only with `DEMUX_FRAME_CNT_EN`.

## Operation
- States: IDLE and RUN.
- Shadow registers `n_q` (effective N, range 1..7) and `m_q` (range 0..3) hold the configuration in use.
  - They load in IDLE on the cycle `mux_valid` is first seen high.
  - They reload on every frame boundary, meaning the last dwell cycle of slot `m_q`-1.
  - `mode` and `switch_clk_cycles` changes at any other time are ignored until that point.
- IDLE → RUN when `mux_valid`=1 and the `mode` being latched is non-zero.
  - That cycle counts as dwell cycle 1 of slot 0: `cnt`=1 after the edge, sample taken immediately if N=1.
  - If the latched `mode` is 0, the block stays in IDLE and `mux_data` is ignored.
- RUN counters:
  - `cnt` counts 1..`n_q`.
  - On the last dwell cycle (`cnt`==`n_q`), `mux_data` is captured into `DS{slot+1}_out` and `ds_valid[slot]` pulses.
  - Then `cnt` returns to 1 and `slot` increments, wrapping from `m_q`-1 to 0.
- RUN → IDLE when `mux_valid`=0.
  - Any partial slot is discarded with no strobe.
  - `DSk_out` hold their values; `slot` returns to 0.
- If a frame-boundary reload sets `m_q`=0, the block returns to IDLE after the final capture.
- At most one `ds_valid` bit is high in any cycle.
- Reset values: `DS1_out`, `DS2_out`, `DS3_out` = 8'h00; `ds_valid` = 3'b000; `slot` = 0; `frame_cnt` = 0; state IDLE.
  - Reset overrides everything, including mid-frame; the next `mux_valid`-high cycle realigns to slot 0.

## Timing
- Capture latency: `DSk_out` and `ds_valid[k]` update on the edge that ends the last dwell cycle and are visible the following cycle. The strobe is exactly one clock wide.
- Slot k's first strobe appears (k+1)·N clocks after the first `mux_valid`-high cycle, where that cycle is cycle 1.
- Steady-state period per stream is M·N clocks.
- `slot` changes on the same edge as the capture.
- `frame_cnt` increments on the frame-boundary edge.
- A `mux_valid` fall and a last dwell cycle in the same cycle: abort wins, with no capture and no strobe.

## Configuration
- `DEMUX_FRAME_CNT_EN` defined:
  - Adds the `frame_cnt[15:0]` output, incremented once per completed frame (slot `m_q`-1 captured).
  - It wraps from 16'hFFFF to 0, holds in IDLE, and clears only on `rst`.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Mode 3, N=2, `mux_valid` rises at cycle 1, `mux_data` = 3,3,50,50,98,98 → DS1_out=3 with `ds_valid`=001 visible at cycle 3, DS2_out=50/010 at cycle 5, DS3_out=98/100 at cycle 7; `frame_cnt`=1 at cycle 7 (macro on).
- Mode 1, N=0 (treated as 1), `mux_data` = 6,9,12 → DS1_out is updated every cycle with `ds_valid[0]` continuously high; DS2_out/DS3_out stay 0.
- Mode 3, N=3; `mode` switched to 2 and N to 1 in the middle of slot 1 → the current frame completes with M=3, N=3, then alternates DS1/DS2 every cycle.
- Mode 2, N=4; `mux_valid` dropped on dwell cycle 4 of slot 1 → no DS2 strobe, `slot`=0, IDLE; DS2_out keeps its prior value.
- Mode 3, N=2; `rst` asserted for one cycle mid-slot 2 → all outputs 0 next cycle; with `mux_valid` still high the block restarts at slot 0 and the first DS1 strobe appears 2 clocks later.
- Mode 0 with `mux_valid`=1 and `mux_data`=8'hAA for 10 cycles → no strobes, `slot`=0, outputs remain 0.
